// File: rtl/dcnn_io_pkg.sv
// ---------------------------------------------------------------------------
// dcnn_io_pkg
// Shared definitions for the run-length image handlers (compress_handler and
// decompress_handler): default widths, controller state encoding and the
// classification of RAM writes issued by the compressor.
// ---------------------------------------------------------------------------
package dcnn_io_pkg;

   localparam int RUN_W_DEF  = 6;    // run-length code width
   localparam int ADDR_W_DEF = 16;   // RAM address width

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      EMIT,
      WRITE,
      FLUSH,
      HDR_HI,
      HDR_LO,
      DONE
   } stateT;

   // What the byte currently held in WRITE is, so the controller knows where
   // the data comes from and where to go once it is acknowledged.
   typedef enum logic [1:0] {
      WK_PAYLOAD,
      WK_FLUSH,
      WK_HDR_HI,
      WK_HDR_LO
   } writeKindT;

endpackage

// File: rtl/compress_handler_bit_packer.sv
// ---------------------------------------------------------------------------
// bit_packer
// Packs RUN_W-bit codes MSB-first into bytes. The accumulator is kept
// left-aligned: the oldest pending bit is always the accumulator MSB, so the
// next byte to write is simply the top 8 bits, and popping is a shift by 8.
// Vacated bits are always zero, which makes flush-padding a pure count change.
//
// Ports
//   clk, RST   clock / synchronous active-high reset
//   clear      discard all pending bits (new image)
//   push,code  append a code (caller guarantees fewer than 8 bits pending)
//   pop        drop the top byte (caller guarantees 8 or more pending)
//   pad        round a partial byte up to 8 pending bits (zero filled)
//   topByte    oldest 8 pending bits
//   hasBits    at least one bit pending
//   pushFills  pushing a code now would leave 8 or more bits pending
// ---------------------------------------------------------------------------
module bit_packer
   import dcnn_io_pkg::*;
#(
   parameter int RUN_W = RUN_W_DEF
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             clear,
   input  logic             push,
   input  logic [RUN_W-1:0] code,
   input  logic             pop,
   input  logic             pad,
   output logic [7:0]       topByte,
   output logic             hasBits,
   output logic             pushFills
);

   localparam int ACC_W = RUN_W + 7;
   localparam int PCW   = $clog2(ACC_W + 1);

   logic [ACC_W-1:0] accReg;
   logic [PCW-1:0]   pendReg;
   logic [ACC_W-1:0] codeAligned;
   logic [PCW-1:0]   pendAfterPush;

   assign codeAligned   = {code, 7'b0};
   assign pendAfterPush = pendReg + PCW'(RUN_W);

   always_ff @(posedge clk) begin
      if (RST || clear) begin
         accReg  <= '0;
         pendReg <= '0;
      end else if (push) begin
         // Drop the new code directly behind the bits already pending.
         accReg  <= accReg | (codeAligned >> pendReg);
         pendReg <= pendAfterPush;
      end else if (pop) begin
         accReg  <= accReg << 8;
         pendReg <= pendReg - PCW'(8);
      end else if (pad) begin
         pendReg <= PCW'(8);
      end
   end

   assign topByte   = accReg[ACC_W-1 -: 8];
   assign hasBits   = (pendReg != '0);
   assign pushFills = (pendAfterPush >= PCW'(8));

endmodule

// File: rtl/compress_handler.sv
// ---------------------------------------------------------------------------
// compress_handler
// Run-length encodes a binary pixel stream into RAM. Codes alternate colour
// starting with colour 0; each code is a RUN_W-bit run length, packed
// MSB-first into bytes that are written one at a time with a
// request/acknowledge handshake.
//
// Build option: define COMPRESS_HANDLER_HEADER_EN to place a 2-byte
// big-endian byte-count header at baseAddr (payload then starts at
// baseAddr+2; header bytes are written after the payload).
//
// Ports
//   clk, RST            clock / synchronous active-high reset
//   start, baseAddr     begin an image at baseAddr (ignored while busy)
//   pixValid/pixBit/pixLast, pixReady   pixel stream handshake
//   ramAddress, ramDataOut, writeSignal, ramDoneWrite   RAM write port
//   busy, done          activity flag / one-cycle completion pulse
//   byteCount           payload bytes written, valid from done
// ---------------------------------------------------------------------------
module compress_handler
   import dcnn_io_pkg::*;
#(
   parameter int RUN_W  = RUN_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              start,
   input  logic [ADDR_W-1:0] baseAddr,
   input  logic              pixValid,
   input  logic              pixBit,
   input  logic              pixLast,
   output logic              pixReady,
   output logic [ADDR_W-1:0] ramAddress,
   output logic [7:0]        ramDataOut,
   output logic              writeSignal,
   input  logic              ramDoneWrite,
   output logic              busy,
   output logic              done,
   output logic [15:0]       byteCount
);

   localparam logic [RUN_W-1:0] MAX_RUN = '1;

`ifdef COMPRESS_HANDLER_HEADER_EN
   localparam logic [ADDR_W-1:0] PAYLOAD_OFS = ADDR_W'(2);
   localparam stateT             AFTER_FLUSH = HDR_HI;
`else
   localparam logic [ADDR_W-1:0] PAYLOAD_OFS = '0;
   localparam stateT             AFTER_FLUSH = DONE;
`endif

   stateT             stateReg, stateNext;
   writeKindT         writeKindReg;
   logic [ADDR_W-1:0] baseReg;
   logic [ADDR_W-1:0] payloadAddrReg;
   logic [15:0]       byteCountReg;
   logic              colorReg;
   logic [RUN_W-1:0]  countReg;
   logic              lastFlagReg;
   // Up to three codes can fall out of one pixel (max, 0, final 1).
   logic [RUN_W-1:0]  codeQReg [3];
   logic [1:0]        qCountReg;

   logic [RUN_W-1:0]  genQ [3];
   logic [1:0]        genN;
   logic [RUN_W-1:0]  genCount;
   logic              genColor;

   logic startAccept, pixAccept, ackWrite, payloadWrite;
   logic pkTopByteValid;
   logic [7:0] pkTopByte;
   logic pkHasBits, pkFills;

   assign startAccept  = (stateReg == IDLE) && start;
   assign pixAccept    = pixValid && pixReady;
   assign ackWrite     = (stateReg == WRITE) && ramDoneWrite;
   assign payloadWrite = (writeKindReg == WK_PAYLOAD) || (writeKindReg == WK_FLUSH);
   assign pkTopByteValid = payloadWrite;

   bit_packer #(.RUN_W(RUN_W)) packer (
      .clk       (clk),
      .RST       (RST),
      .clear     (startAccept),
      .push      (stateReg == EMIT),
      .code      (codeQReg[0]),
      .pop       (ackWrite && payloadWrite),
      .pad       ((stateReg == FLUSH) && pkHasBits),
      .topByte   (pkTopByte),
      .hasBits   (pkHasBits),
      .pushFills (pkFills)
   );

   // Codes produced by the pixel being offered now, if it is accepted.
   always_comb begin
      genQ     = '{default: '0};
      genN     = 2'd0;
      genCount = countReg;
      genColor = colorReg;
      if (pixBit != colorReg) begin
         genQ[0]  = countReg;
         genN     = 2'd1;
         genCount = RUN_W'(1);
         genColor = pixBit;
         if (pixLast) begin
            genQ[1] = RUN_W'(1);
            genN    = 2'd2;
         end
      end else if (countReg == MAX_RUN) begin
         // Run overflow: close it, insert an empty run of the other colour,
         // and carry on with this pixel as the first of a fresh run.
         genQ[0]  = MAX_RUN;
         genQ[1]  = '0;
         genN     = 2'd2;
         genCount = RUN_W'(1);
         if (pixLast) begin
            genQ[2] = RUN_W'(1);
            genN    = 2'd3;
         end
      end else begin
         genCount = countReg + RUN_W'(1);
         if (pixLast) begin
            genQ[0] = countReg + RUN_W'(1);
            genN    = 2'd1;
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (RST) stateReg <= IDLE;
      else     stateReg <= stateNext;
   end

   // Next-state logic
   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         IDLE:   if (start) stateNext = RUN;
         RUN:    if (qCountReg != 2'd0) stateNext = EMIT;
                 else if (lastFlagReg)  stateNext = FLUSH;
         EMIT:   stateNext = pkFills ? WRITE : RUN;
         WRITE:  if (ramDoneWrite) begin
                    case (writeKindReg)
                       WK_PAYLOAD: stateNext = (qCountReg != 2'd0) ? EMIT : RUN;
                       WK_FLUSH:   stateNext = AFTER_FLUSH;
                       WK_HDR_HI:  stateNext = HDR_LO;
                       default:    stateNext = DONE;
                    endcase
                 end
         FLUSH:  stateNext = pkHasBits ? WRITE : AFTER_FLUSH;
         HDR_HI: stateNext = WRITE;
         HDR_LO: stateNext = WRITE;
         DONE:   stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Pending code queue: filled by an accepted pixel, drained one per EMIT.
   for (genvar gi = 0; gi < 3; gi++) begin : g_codeQ
      always_ff @(posedge clk) begin
         if (RST || startAccept) begin
            codeQReg[gi] <= '0;
         end else if (pixAccept) begin
            codeQReg[gi] <= genQ[gi];
         end else if (stateReg == EMIT) begin
            if (gi < 2) codeQReg[gi] <= codeQReg[(gi < 2) ? gi + 1 : gi];
            else        codeQReg[gi] <= '0;
         end
      end
   end

   // Datapath / bookkeeping registers
   always_ff @(posedge clk) begin
      if (RST) begin
         writeKindReg   <= WK_PAYLOAD;
         baseReg        <= '0;
         payloadAddrReg <= '0;
         byteCountReg   <= '0;
         colorReg       <= 1'b0;
         countReg       <= '0;
         lastFlagReg    <= 1'b0;
         qCountReg      <= 2'd0;
      end else begin
         case (stateReg)
            IDLE: if (start) begin
               baseReg        <= baseAddr;
               payloadAddrReg <= baseAddr + PAYLOAD_OFS;
               byteCountReg   <= '0;
               colorReg       <= 1'b0;
               countReg       <= '0;
               lastFlagReg    <= 1'b0;
               qCountReg      <= 2'd0;
            end
            RUN: if (pixAccept) begin
               qCountReg   <= genN;
               countReg    <= genCount;
               colorReg    <= genColor;
               lastFlagReg <= pixLast;
            end
            EMIT: begin
               qCountReg    <= qCountReg - 2'd1;
               writeKindReg <= WK_PAYLOAD;
            end
            WRITE: if (ramDoneWrite && payloadWrite) begin
               payloadAddrReg <= payloadAddrReg + ADDR_W'(1);
               byteCountReg   <= byteCountReg + 16'd1;
            end
            FLUSH:  writeKindReg <= WK_FLUSH;
            HDR_HI: writeKindReg <= WK_HDR_HI;
            HDR_LO: writeKindReg <= WK_HDR_LO;
            default: ;
         endcase
      end
   end

   // Outputs. Address and data only carry meaning while a write is held,
   // and are driven from registers so they stay stable through the wait.
   always_comb begin
      pixReady    = (stateReg == RUN) && (qCountReg == 2'd0) && !lastFlagReg;
      writeSignal = (stateReg == WRITE);
      busy        = (stateReg != IDLE) && (stateReg != DONE);
      done        = (stateReg == DONE);
      byteCount   = byteCountReg;
      ramAddress  = '0;
      ramDataOut  = '0;
      if (stateReg == WRITE) begin
         case (writeKindReg)
            WK_HDR_HI: begin
               ramAddress = baseReg;
               ramDataOut = byteCountReg[15:8];
            end
            WK_HDR_LO: begin
               ramAddress = baseReg + ADDR_W'(1);
               ramDataOut = byteCountReg[7:0];
            end
            default: begin
               ramAddress = payloadAddrReg;
               ramDataOut = pkTopByteValid ? pkTopByte : 8'h00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_compress_handler.sv
// ---------------------------------------------------------------------------
// tb_compress_handler
// Self-checking bench for compress_handler (RUN_W=6, ADDR_W=16). Directed
// table vectors, a reset-during-write sequence, and random images checked
// against a run-list reference model. Build with COMPRESS_HANDLER_HEADER_EN
// defined to check the header variant.
// ---------------------------------------------------------------------------
module tb_compress_handler;

   localparam int RUN_W  = 6;
   localparam int ADDR_W = 16;
   localparam int MAXR   = (1 << RUN_W) - 1;
`ifdef COMPRESS_HANDLER_HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif

   logic              clk = 1'b0;
   logic              RST = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] baseAddr = '0;
   logic              pixValid = 1'b0;
   logic              pixBit = 1'b0;
   logic              pixLast = 1'b0;
   logic              pixReady;
   logic [ADDR_W-1:0] ramAddress;
   logic [7:0]        ramDataOut;
   logic              writeSignal;
   logic              ramDoneWrite = 1'b0;
   logic              busy;
   logic              done;
   logic [15:0]       byteCount;

   compress_handler #(.RUN_W(RUN_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .RST(RST), .start(start), .baseAddr(baseAddr),
      .pixValid(pixValid), .pixBit(pixBit), .pixLast(pixLast), .pixReady(pixReady),
      .ramAddress(ramAddress), .ramDataOut(ramDataOut), .writeSignal(writeSignal),
      .ramDoneWrite(ramDoneWrite), .busy(busy), .done(done), .byteCount(byteCount)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
   } wrT;

   wrT wrLog[$];
   wrT expWr[$];
   int expBc;

   // ---------------- RAM responder ----------------
   int          ackDelay = 1;
   bit          strayEn  = 1'b0;
   bit          inWrite  = 1'b0;
   bit          ackGiven = 1'b0;
   int          waitCnt  = 0;
   logic [15:0] holdA;
   logic [7:0]  holdD;

   initial begin
      forever begin
         @(negedge clk);
         if (RST) begin
            inWrite = 1'b0; ackGiven = 1'b0; ramDoneWrite = 1'b0;
         end else if (ackGiven) begin
            ackGiven = 1'b0;
            ramDoneWrite = 1'b0;
            check("writeDropAfterAck", writeSignal, 0);
         end else if (writeSignal) begin
            if (!inWrite) begin
               inWrite = 1'b1; waitCnt = 0;
               holdA = ramAddress; holdD = ramDataOut;
               wrLog.push_back('{addr: ramAddress, data: ramDataOut});
            end else begin
               waitCnt++;
               check("addrStable", ramAddress, holdA);
               check("dataStable", ramDataOut, holdD);
            end
            check("pixReadyDuringWrite", pixReady, 0);
            if (waitCnt >= ackDelay - 1) begin
               ramDoneWrite = 1'b1; ackGiven = 1'b1; inWrite = 1'b0;
            end else begin
               ramDoneWrite = 1'b0;
            end
         end else begin
            inWrite = 1'b0;
            ramDoneWrite = strayEn ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
   end

   // ---------------- reference model ----------------
   task automatic modelImage(input bit pix[$], input logic [15:0] base);
      int codes[$];
      bit bq[$];
      int color = 0, run = 0, len;
      logic [7:0] b;
      for (int k = 0; k <= pix.size(); k++) begin
         if (k < pix.size() && int'(pix[k]) == color) begin
            run++;
         end else begin
            len = run;
            while (len > MAXR) begin
               codes.push_back(MAXR); codes.push_back(0); len -= MAXR;
            end
            codes.push_back(len);
            color ^= 1; run = 1;
         end
      end
      foreach (codes[c])
         for (int s = RUN_W - 1; s >= 0; s--) bq.push_back(bit'((codes[c] >> s) & 1));
      while (bq.size() % 8 != 0) bq.push_back(1'b0);
      expWr.delete();
      expBc = bq.size() / 8;
      for (int k = 0; k < expBc; k++) begin
         for (int s = 0; s < 8; s++) b[7-s] = bq[8*k+s];
         expWr.push_back('{addr: base + 16'(2*HDR) + 16'(k), data: b});
      end
      if (HDR != 0) begin
         expWr.push_back('{addr: base, data: 8'(expBc >> 8)});
         expWr.push_back('{addr: base + 16'd1, data: 8'(expBc)});
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic startImage(input logic [15:0] base);
      wrLog.delete();
      @(negedge clk); start = 1'b1; baseAddr = base;
      @(negedge clk); start = 1'b0; baseAddr = 16'($urandom);
      check("busyAfterStart", busy, 1);
   endtask

   task automatic feedPixels(input bit pix[$], input bit gaps);
      int i = 0, guard = 0;
      bit acc;
      while (i < pix.size() && guard < 20000) begin
         pixValid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         pixBit   = pix[i];
         pixLast  = (i == pix.size() - 1);
         // stray start requests while busy must be ignored
         start    = gaps && ($urandom_range(0, 15) == 0);
         baseAddr = 16'($urandom);
         acc = pixValid && pixReady;
         @(negedge clk);
         if (acc) i++;
         guard++;
      end
      pixValid = 1'b0; pixLast = 1'b0; start = 1'b0;
      if (guard >= 20000) check("pixelFeedTimeout", 1, 0);
   endtask

   task automatic waitDone(input string tag);
      int guard = 0, dones = 0;
      while (!done && guard < 3000) begin @(negedge clk); guard++; end
      check("doneSeen", done, 1);
      check("busyLowAtDone", busy, 0);
      check("byteCountAtDone", byteCount, expBc);
      if (done) dones = 1;
      for (int k = 0; k < 6; k++) begin @(negedge clk); if (done) dones++; end
      check("singleDonePulse", dones, 1);
      check("byteCountHeld", byteCount, expBc);
      check("writeCount", wrLog.size(), expWr.size());
      for (int k = 0; k < wrLog.size() && k < expWr.size(); k++) begin
         check("writeAddr", wrLog[k].addr, expWr[k].addr);
         check("writeData", wrLog[k].data, expWr[k].data);
      end
      $display("image %s: %0d writes, byteCount %0d", tag, wrLog.size(), byteCount);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [127:0] pix;
      int           n;
      logic [15:0]  base;
      int           ack;
      int           nb;
      logic [7:0]   b0, b1, b2;
   } vecT;

   vecT vecs[6];

   task automatic tableExpect(input vecT v);
      logic [7:0] bs[3];
      bs[0] = v.b0; bs[1] = v.b1; bs[2] = v.b2;
      expWr.delete();
      expBc = v.nb;
      for (int k = 0; k < v.nb; k++)
         expWr.push_back('{addr: v.base + 16'(2*HDR) + 16'(k), data: bs[k]});
      if (HDR != 0) begin
         expWr.push_back('{addr: v.base, data: 8'(v.nb >> 8)});
         expWr.push_back('{addr: v.base + 16'd1, data: 8'(v.nb)});
      end
   endtask

   task automatic runVec(input vecT v, input string tag);
      bit q[$];
      for (int k = 0; k < v.n; k++) q.push_back(v.pix[k]);
      tableExpect(v);
      ackDelay = v.ack;
      startImage(v.base);
      feedPixels(q, 1'b0);
      waitDone(tag);
   endtask

   initial begin
      bit q[$];
      int guard, dones, fp, len;
      logic [15:0] base;

      vecs[0] = '{pix: 128'h18, n: 5,  base: 16'h0000, ack: 1, nb: 2, b0: 8'h0C, b1: 8'h20, b2: 8'h00};
      vecs[1] = '{pix: 128'h01, n: 1,  base: 16'h0000, ack: 1, nb: 2, b0: 8'h00, b1: 8'h10, b2: 8'h00};
      vecs[2] = '{pix: 128'h00, n: 64, base: 16'h0000, ack: 1, nb: 3, b0: 8'hFC, b1: 8'h00, b2: 8'h40};
      vecs[3] = '{pix: 128'h18, n: 5,  base: 16'h0000, ack: 6, nb: 2, b0: 8'h0C, b1: 8'h20, b2: 8'h00};
      vecs[4] = '{pix: 128'h18, n: 5,  base: 16'h0100, ack: 1, nb: 2, b0: 8'h0C, b1: 8'h20, b2: 8'h00};
      vecs[5] = '{pix: 128'h07, n: 3,  base: 16'h1234, ack: 2, nb: 2, b0: 8'h00, b1: 8'h30, b2: 8'h00};

      // Reset state; start asserted together with reset must be ignored.
      RST = 1'b1; start = 1'b1;
      repeat (3) @(negedge clk);
      check("rstPixReady", pixReady, 0);
      check("rstWriteSignal", writeSignal, 0);
      check("rstDone", done, 0);
      check("rstBusy", busy, 0);
      check("rstByteCount", byteCount, 0);
      check("rstRamAddress", ramAddress, 0);
      check("rstRamDataOut", ramDataOut, 0);
      RST = 1'b0; start = 1'b0;
      @(negedge clk);
      check("busyAfterRstStart", busy, 0);

      for (int v = 0; v < 6; v++) runVec(vecs[v], $sformatf("vec%0d", v));

      // Reset while a write is being held.
      tableExpect(vecs[0]);
      ackDelay = 30;
      startImage(16'h0000);
      q.delete();
      for (int k = 0; k < 5; k++) q.push_back(vecs[0].pix[k]);
      feedPixels(q, 1'b0);
      guard = 0;
      while (!writeSignal && guard < 100) begin @(negedge clk); guard++; end
      check("writeBeforeReset", writeSignal, 1);
      RST = 1'b1;
      @(negedge clk);
      check("rstInWriteWriteSignal", writeSignal, 0);
      check("rstInWriteBusy", busy, 0);
      check("rstInWriteDone", done, 0);
      RST = 1'b0;
      dones = 0;
      for (int k = 0; k < 10; k++) begin @(negedge clk); if (done) dones++; end
      check("noDoneAfterAbort", dones, 0);
      runVec(vecs[0], "afterReset");

      // Random images with gaps, stray acks and stray starts.
      strayEn = 1'b1;
      for (int t = 0; t < 20; t++) begin
         case ($urandom_range(0, 2))
            0: fp = 2;
            1: fp = 8;
            default: fp = 80;
         endcase
         len = $urandom_range(1, 160);
         q.delete();
         q.push_back(1'($urandom_range(0, 1)));
         for (int k = 1; k < len; k++)
            q.push_back(q[k-1] ^ ($urandom_range(0, fp - 1) == 0));
         base = 16'($urandom_range(0, 16'hFF00));
         modelImage(q, base);
         ackDelay = $urandom_range(1, 4);
         startImage(base);
         feedPixels(q, 1'b1);
         waitDone($sformatf("rand%0d len%0d", t, len));
      end
      strayEn = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/compress_handler.md
COMPRESS_HANDLER -- requirements
Module: compress_handler

Interface
REQ-001 SHALL have parameter RUN_W, default 6, giving the run-length code width in bits (legal range 2..8).
REQ-002 SHALL have parameter ADDR_W, default 16, giving the RAM address width.
REQ-003 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin a new image.
- baseAddr  in  ADDR_W  RAM start address, sampled on an accepted start.
- pixValid  in  1  pixel offered.
- pixBit  in  1  binary pixel value.
- pixLast  in  1  marks the final pixel of the image.
- pixReady  out  1  pixel accepted when pixValid && pixReady.
- ramAddress  out  ADDR_W  write address.
- ramDataOut  out  8  write byte.
- writeSignal  out  1  write request.
- ramDoneWrite  in  1  RAM write acknowledge.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle completion pulse.
- byteCount  out  16  number of payload bytes written.

Function
REQ-004 SHALL run-length encode a binary pixel stream (the inverse of decompress_handler):
- Codes alternate color, starting with color 0.
- Each code is the run length, RUN_W bits wide.
- A leading 1-pixel produces a first code of 0.
REQ-005 SHALL pack codes MSB-first into bytes with a bit index that carries across byte boundaries.
- Each full byte is written to ramAddress, starting at the payload base; the address increments by 1 after each acknowledged byte.
REQ-006 SHALL use states IDLE, RUN, EMIT, WRITE, FLUSH, HDR_HI, HDR_LO, DONE with these transitions:
- IDLE->RUN on start.
- RUN->EMIT when a code is due.
- EMIT->WRITE when 8 or more bits are pending, else EMIT->RUN.
- WRITE->EMIT/RUN on acknowledge.
- RUN->FLUSH after the pixLast code is emitted.
- FLUSH->(HDR_HI)->DONE.
- DONE->IDLE after 1 cycle.
REQ-007 SHALL assert pixReady only in RUN with no pending code and no pending write.
REQ-008 SHALL emit a code in each of these cases:
- An accepted pixel differs from the current color.
- The pixLast pixel is accepted (its pixel is counted first).
- A same-color pixel arrives with count == 2^RUN_W-1: emit the max code, then a 0 code, then set count=1.
REQ-009 SHALL hold writeSignal high with ramAddress and ramDataOut stable until ramDoneWrite is sampled high.
- SHALL deassert writeSignal on the following cycle.
- SHALL keep a minimum of 1 idle cycle between writes.
REQ-010 SHALL, in FLUSH, pad any nonzero remaining bits with zeros to a full byte and write it; with zero remaining bits, no write occurs.
REQ-011 SHALL pulse done for exactly 1 cycle in DONE, hold byteCount valid from done until the next accepted start, and deassert busy in the same cycle done is high.
REQ-012 SHALL ignore start while busy, and ignore start in the same cycle RST is high.
REQ-013 SHALL tolerate ramDoneWrite asserted outside WRITE by ignoring it.

Reset
REQ-014 SHALL, on RST high at a clock edge, force IDLE, clear all counters and the accumulator, and drive these outputs: pixReady=0, writeSignal=0, done=0, busy=0, byteCount=0, ramAddress=0, ramDataOut=0.
REQ-015 SHALL, on RST during WRITE, drop writeSignal at that edge and abandon the image; no partial completion is signalled.

Configuration
REQ-016 SHALL support the macro COMPRESS_HANDLER_HEADER_EN:
- When defined: the payload starts at baseAddr+2. After FLUSH, byteCount is written big-endian as 2 header bytes (HDR_HI to baseAddr, HDR_LO to baseAddr+1) using the REQ-009 handshake.
- When undefined: the payload starts at baseAddr, and HDR_HI/HDR_LO are never entered.

Structure
REQ-017 SHALL take the state enum typedef and the default RUN_W/ADDR_W constants from the shared package dcnn_io_pkg, which decompress_handler also uses.
REQ-018 SHALL instantiate one sub-module, bit_packer, containing:
- A (RUN_W+7)-bit accumulator and pending-bit count.
- Interfaces: push code, pop byte, and flush-pad.

Verification (RUN_W=6, no header unless stated)
REQ-019 Pixels 0,0,0,1,1(last), base 0x0000, ack 1 cycle after request -> codes 3,2; writes 0x0000=0x0C, 0x0001=0x20; byteCount=2; one done pulse.
REQ-020 Single pixel 1(last) -> codes 0,1; writes 0x00 then 0x10; byteCount=2.
REQ-021 64 consecutive 0s (last on the 64th) -> codes 63,0,1; writes 0xFC, 0x00, 0x40; byteCount=3.
REQ-022 ramDoneWrite held low 5 cycles during the first write -> writeSignal, ramAddress and ramDataOut stable for all 5 cycles; pixReady=0 throughout; output bytes unchanged.
REQ-023 Header enabled, REQ-019 stimulus, base 0x0100 -> writes 0x0102=0x0C, 0x0103=0x20, 0x0100=0x00, 0x0101=0x02, in that order.
REQ-024 RST pulsed while writeSignal=1 -> writeSignal=0 and busy=0 at that edge; no done; a new start then produces the REQ-019 result exactly.
